// File: rtl/pid_scheduler.sv
// pid_scheduler: round-robin scheduler sharing one PID engine among NUM_CH channels.
// Optional engine watchdog enabled by defining PID_SCHED_TIMEOUT_EN.
module pid_scheduler #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        req,
  input  logic [8*NUM_CH-1:0]      setpoint_bus,
  input  logic [8*NUM_CH-1:0]      feedback_bus,
  input  logic [NUM_CH-1:0]        ctx_clear,
  output logic [NUM_CH-1:0]        ack,
  output logic [7:0]               ctrl_out,
  output logic [2:0]               ctrl_ch,
  output logic                     ctrl_valid,
  output logic                     busy,
  output logic                     eng_start,
  output logic [7:0]               eng_setpoint,
  output logic [7:0]               eng_feedback,
  output logic signed [15:0]       eng_integral,
  output logic signed [8:0]        eng_prev_err,
  input  logic                     eng_done,
  input  logic [7:0]               eng_result,
  input  logic signed [15:0]       eng_integral_nxt,
  input  logic signed [8:0]        eng_prev_err_nxt,
  output logic                     err_timeout
);

  typedef enum logic [1:0] {StIdle, StStart, StWait, StWb} state_e;

  localparam logic [3:0] NumChW = 4'(NUM_CH);
  localparam logic [2:0] LastCh = 3'(NUM_CH - 1);

  state_e              state_q, state_d;
  logic [2:0]          grant_q, ptr_q, pick, offset;
  logic [3:0]          pick_sum;
  logic [NUM_CH-1:0]   req_rot;
  logic                found;
  logic                timeout_q, timeout_hit;
  logic signed [15:0]  integ_q [NUM_CH];
  logic signed [8:0]   prev_q  [NUM_CH];
  logic signed [15:0]  integ_cap_q, sel_int, eng_int_q;
  logic signed [8:0]   prev_cap_q, sel_prev, eng_prev_q;
  logic [7:0]          sel_sp, sel_fb, eng_sp_q, eng_fb_q, ctrl_q;
  logic [2:0]          ctrl_ch_q;

  // Rotate requests so bit 0 is the search start, then map the winner back.
  always_comb begin
    req_rot = NUM_CH'({req, req} >> ptr_q);
    found   = 1'b0;
    offset  = '0;
    for (int unsigned j = 0; j < NUM_CH; j++) begin
      if (!found && req_rot[j]) begin
        found  = 1'b1;
        offset = 3'(j);
      end
    end
    pick_sum = {1'b0, ptr_q} + {1'b0, offset};
    if (pick_sum >= NumChW) pick_sum = pick_sum - NumChW;
    pick = pick_sum[2:0];
  end

  always_comb begin
    sel_sp   = '0;
    sel_fb   = '0;
    sel_int  = '0;
    sel_prev = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (pick == 3'(i)) begin
        sel_sp   = setpoint_bus[8*i +: 8];
        sel_fb   = feedback_bus[8*i +: 8];
        sel_int  = integ_q[i];
        sel_prev = prev_q[i];
      end
    end
  end

`ifdef PID_SCHED_TIMEOUT_EN
  localparam int unsigned TcW    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TcW-1:0] TcLast = TcW'(TIMEOUT_CYC - 1);

  logic [TcW-1:0] tcnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt_q <= '0;
    end else if (state_q == StWait && !eng_done) begin
      tcnt_q <= tcnt_q + TcW'(1);
    end else begin
      tcnt_q <= '0;
    end
  end

  assign timeout_hit = (state_q == StWait) && !eng_done && (tcnt_q == TcLast);
  assign err_timeout = (state_q == StWb) && timeout_q;
`else
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (found) state_d = StStart;
      StStart: state_d = StWait;
      StWait:  if (eng_done || timeout_hit) state_d = StWb;
      StWb:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      ptr_q       <= '0;
      timeout_q   <= 1'b0;
      eng_sp_q    <= '0;
      eng_fb_q    <= '0;
      eng_int_q   <= '0;
      eng_prev_q  <= '0;
      integ_cap_q <= '0;
      prev_cap_q  <= '0;
      ctrl_q      <= '0;
      ctrl_ch_q   <= '0;
    end else begin
      state_q <= state_d;
      // Operands and context are frozen at grant; later clears do not touch them.
      if (state_q == StIdle && found) begin
        grant_q    <= pick;
        eng_sp_q   <= sel_sp;
        eng_fb_q   <= sel_fb;
        eng_int_q  <= sel_int;
        eng_prev_q <= sel_prev;
        timeout_q  <= 1'b0;
      end
      if (state_q == StWait) begin
        if (eng_done) begin
          integ_cap_q <= eng_integral_nxt;
          prev_cap_q  <= eng_prev_err_nxt;
          ctrl_q      <= eng_result;
          ctrl_ch_q   <= grant_q;
        end else if (timeout_hit) begin
          timeout_q <= 1'b1;
        end
      end
      if (state_q == StWb) ptr_q <= (grant_q == LastCh) ? 3'd0 : grant_q + 3'd1;
    end
  end

  // Clear wins over a same-cycle write-back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        integ_q[i] <= '0;
        prev_q[i]  <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (ctx_clear[i]) begin
          integ_q[i] <= '0;
          prev_q[i]  <= '0;
        end else if (state_q == StWb && !timeout_q && grant_q == 3'(i)) begin
          integ_q[i] <= integ_cap_q;
          prev_q[i]  <= prev_cap_q;
        end
      end
    end
  end

  always_comb begin
    ack = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      ack[i] = (state_q == StWb) && (grant_q == 3'(i));
    end
  end

  assign ctrl_valid   = (state_q == StWb) && !timeout_q;
  assign ctrl_out     = ctrl_q;
  assign ctrl_ch      = ctrl_ch_q;
  assign busy         = (state_q != StIdle);
  assign eng_start    = (state_q == StStart);
  assign eng_setpoint = eng_sp_q;
  assign eng_feedback = eng_fb_q;
  assign eng_integral = eng_int_q;
  assign eng_prev_err = eng_prev_q;

endmodule

// File: doc/pid_scheduler.md
PID_SCHEDULER -- requirements
Module: pid_scheduler

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning number of control channels sharing one PID engine (legal range 2..8).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 16, meaning maximum engine wait cycles (used only with PID_SCHED_TIMEOUT_EN).
REQ-003 SHALL have port clk  in  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port req  in  NUM_CH  per-channel compute request; a level, held until the matching ack.
REQ-006 SHALL have port setpoint_bus  in  8*NUM_CH  unsigned setpoint per channel; channel i occupies bits [8i+7:8i].
REQ-007 SHALL have port feedback_bus  in  8*NUM_CH  unsigned feedback per channel, packed the same way.
REQ-008 SHALL have port ctx_clear  in  NUM_CH  per-channel context clear strobe.
REQ-009 SHALL have port ack  out  NUM_CH  one-cycle completion pulse to the serviced channel.
REQ-010 SHALL have port ctrl_out  out  8  most recent control value; ctrl_ch  out  3  its channel index; ctrl_valid  out  1  one-cycle pulse when both update.
REQ-011 SHALL have port busy  out  1  high in every state other than IDLE.
REQ-012 SHALL have engine ports eng_start out 1, eng_setpoint out 8, eng_feedback out 8, eng_integral out 16 signed, eng_prev_err out 9 signed.
REQ-013 SHALL have engine ports eng_done in 1, eng_result in 8, eng_integral_nxt in 16 signed, eng_prev_err_nxt in 9 signed.
REQ-014 SHALL have port err_timeout  out  1  one-cycle pulse on engine timeout.

Function
REQ-015 SHALL implement FSM IDLE -> START -> WAIT -> WB -> IDLE.
- IDLE: if any req bit is set, grant channel, capture its setpoint/feedback, go to START.
REQ-016 SHALL grant round-robin: search starts at (last granted + 1) mod NUM_CH; after reset, search starts at channel 0.
REQ-017 SHALL hold, per channel, a 16-bit signed integral context and a 9-bit signed prev_error context.
REQ-018 SHALL, in START, pulse eng_start for one cycle, drive the captured operands and the granted channel's context on eng_* outputs, and go to WAIT.
REQ-019 SHALL keep eng_* operand outputs stable from START until leaving WAIT.
REQ-020 SHALL, in WAIT, on eng_done=1 capture eng_result, eng_integral_nxt and eng_prev_err_nxt, then go to WB.
REQ-021 SHALL ignore eng_done outside WAIT.
REQ-022 SHALL, in WB, do all of the following, then return to IDLE:
- write the captured context back to the granted channel;
- update ctrl_out/ctrl_ch;
- pulse ctrl_valid;
- pulse ack[granted];
- update the last-granted pointer.
REQ-023 SHALL give a minimum latency of 3 cycles from req sampled in IDLE to ack, when eng_done returns the cycle after eng_start.
REQ-024 SHALL complete a captured request even if its req drops before ack; a protocol violation, not an error.
REQ-025 SHALL, when ctx_clear[i] is set, zero channel i context on the next edge; ctx_clear takes priority over a simultaneous WB write to the same channel.
REQ-026 SHALL NOT apply ctx_clear to operands already driven to the engine; the in-flight computation uses the old context.
REQ-027 SHALL sample a request that arrives during busy only after return to IDLE; no queueing beyond the req levels.

Reset
REQ-028 SHALL, on rst, immediately force state IDLE and clear all of the following:
- ack, ctrl_valid, eng_start, err_timeout, busy = 0;
- ctrl_out = 0x00, ctrl_ch = 0;
- eng_* operand outputs = 0;
- all contexts = 0;
- round-robin pointer so channel 0 wins next;
- timeout counter = 0.
REQ-029 SHALL abandon any in-flight computation on rst without ack; an eng_done arriving after reset is ignored.

Configuration
REQ-030 SHALL, with PID_SCHED_TIMEOUT_EN defined, count WAIT cycles; on reaching TIMEOUT_CYC without eng_done it SHALL:
- pulse err_timeout and ack[granted];
- leave context and ctrl_out unchanged, with no ctrl_valid;
- advance the pointer;
- go to IDLE.
REQ-031 SHALL, without PID_SCHED_TIMEOUT_EN, wait in WAIT indefinitely and tie err_timeout to 0.

Verification
REQ-032 SHALL check: rst released, req=0001, ch0 setpoint=0x80 feedback=0x40, engine returns 0x55 the cycle after start -> ack[0] and ctrl_valid 3 cycles after req, ctrl_out=0x55, ctrl_ch=0.
REQ-033 SHALL check: req=1111 held through four services -> grants in order 0,1,2,3, then 0 again; no channel granted twice before all others.
REQ-034 SHALL check: ch2 serviced with eng_integral_nxt=0x0123 -> next ch2 service drives eng_integral=0x0123; with ctx_clear[2] pulsed in between, drives 0x0000.
REQ-035 SHALL check: ctx_clear[1] in the same cycle as WB for ch1 -> ch1 context reads 0 afterwards.
REQ-036 SHALL check: rst asserted in WAIT -> outputs at reset values before the next edge; a later eng_done produces no ack.
REQ-037 SHALL check, with PID_SCHED_TIMEOUT_EN: eng_done never asserted -> err_timeout and ack pulse after 16 WAIT cycles; ctrl_out unchanged.
